lsq_dispatch_packer: RTL and testbench
======================================

// Module: lsq_dispatch_packer
// PURPOSE
// - Registered, credit-checked successor of the 4-wide load/store index packer between dispatch and the LSQ.
// - Each cycle takes a DISP_W-wide dispatch bundle, takes the ROB index of every load and every store,
//   and packs them into dense, lowest-slot-first arrays.
// - Holds the packed bundle in an output register with a valid/ready handshake toward the LSQ.
// - Checks load-queue and store-queue credits and back-pressures dispatch; handles ROB wrap-around and flush.
// PARAMETERS
// DISP_W     4    instructions per dispatch bundle
// ROB_IDX_W  7    ROB index width
// ROB_DEPTH  128  ROB entries; index wraps modulo ROB_DEPTH (may be non-power-of-2, <= 2**ROB_IDX_W)
// LQ_DEPTH   16   load-queue entries (initial load credits)
// SQ_DEPTH   16   store-queue entries (initial store credits)
// PORTS
// clk             in   1                          clock, rising edge
// rst_n           in   1                          asynchronous active-low reset
// flush           in   1                          pipeline flush (mispredict/exception)
// disp_valid      in   1                          dispatch bundle valid
// disp_ready      out  1                          bundle accepted when disp_valid&&disp_ready
// disp_is_ld      in   DISP_W                     bit i: instruction i is a load
// disp_is_st      in   DISP_W                     bit i: instruction i is a store
// rob_base_idx    in   ROB_IDX_W                  ROB index of instruction 0
// lsq_valid       out  1                          packed bundle valid
// lsq_ready       in   1                          LSQ accepts bundle
// ld_indx_to_lsq  out  DISP_W*(ROB_IDX_W+1)       slot k = {valid, rob_idx}, slot 0 in LSBs
// st_indx_to_lsq  out  DISP_W*(ROB_IDX_W+1)       same layout, stores
// ld_cnt, st_cnt  out  $clog2(DISP_W+1)           number of valid load/store slots
// ld_free_cnt     in   $clog2(LQ_DEPTH+1)         load entries released by LSQ this cycle
// st_free_cnt     in   $clog2(SQ_DEPTH+1)         store entries released by LSQ this cycle
// credit_err      out  1                          sticky: a credit counter would exceed its depth
// BEHAVIOUR
// - Reset: lsq_valid=0; all slots=0; ld_cnt=st_cnt=0; credit_err=0; lq_cred=LQ_DEPTH; sq_cred=SQ_DEPTH.
// - Index of instruction i = (rob_base_idx+i) mod ROB_DEPTH; e.g. base 126, depth 128: idx 126,127,0,1.
// - Packing: slot k holds the k-th set bit of disp_is_ld in ascending i; unused slots = all-zero (valid=0).
//   Stores are packed the same way. An instruction with both bits set occupies one load AND one store slot.
//   Every occupied slot carries valid=1.
// - nld/nst = popcount(disp_is_ld/disp_is_st).
// - disp_ready = !flush && (!lsq_valid || lsq_ready) && nld<=lq_cred && nst<=sq_cred.
//   Combinational from disp_is_*; this path is permitted.
// - Accept: the output register loads the packed bundle next edge; lsq_valid=1. Latency 1 cycle.
// - Hold: lsq_valid && !lsq_ready keeps all outputs stable.
// - Drain: lsq_valid && lsq_ready && no accept: lsq_valid->0 next edge.
// - Credits per edge: cred <= cred - alloc + free.
//   - alloc = nld/nst if accepted, else 0.
//   - Allocate and free in the same cycle are both applied.
//   - If the result would exceed depth: clamp to depth, set credit_err (cleared only by reset).
// - Flush (highest priority):
//   - Next edge lsq_valid=0 and slots cleared.
//   - The bundle presented that cycle is not accepted.
//   - A held bundle not taken by the LSQ that cycle (!lsq_ready) returns its ld_cnt/st_cnt credits.
//   - A held bundle with lsq_ready=1 in the flush cycle counts as delivered; no credit return.
//   - Released entries come back via *_free_cnt.
// - nld==0 and nst==0 with disp_valid: still accepted (credits permitting trivially); lsq_valid=1 with ld_cnt=st_cnt=0.
// - Reset asserted mid-operation: immediate return to reset values; the in-flight bundle is discarded.
// STRUCTURE
// - Package lsq_pkg: ROB_IDX_W, DISP_W defaults, slot typedef {logic v; logic [ROB_IDX_W-1:0] idx}.
// - Sub-module lsq_slot_compact (combinational prefix-sum compactor):
//   - in: mask[DISP_W], base index; out: packed slots, count.
//   - Instantiated twice (loads, stores). Top level holds the output register, the two credit counters and the flush logic.
// TESTING
// - Reset, base=5, ld=4'b1010, st=4'b0101, lsq_ready=1 -> next cycle ld slots {1,6},{1,8},0,0, ld_cnt=2;
//   st slots {1,5},{1,7},0,0; lq_cred=14.
// - base=126, ld=4'b1111 -> ld slots idx 126,127,0,1 all valid; ROB_DEPTH=100, base=98 -> idx 98,99,0,1.
// - lq_cred=1, bundle ld=4'b0011 -> disp_ready=0.
//   Same cycle ld_free_cnt=1 -> still 0 that cycle; next cycle lq_cred=2 -> accepted.
// - lsq_ready=0 for 3 cycles with a bundle held -> outputs stable, disp_ready=0.
//   lsq_ready=1 -> new bundle loaded the same edge.
// - Held bundle ld_cnt=2, lq_cred=10, flush with lsq_ready=0 -> lsq_valid=0 next, lq_cred=12.
// - lq_cred=16, ld_free_cnt=1, no alloc -> lq_cred stays 16, credit_err=1 and stays set until rst_n.

Source files
------------

// File: rtl/lsq_pkg.sv
// Shared defaults and types for the dispatch-to-LSQ index packer.
package lsq_pkg;

  localparam int unsigned DispWDefault   = 4;
  localparam int unsigned RobIdxWDefault = 7;

  // One packed slot as seen by the LSQ: {valid, rob_idx}.
  typedef struct packed {
    logic                      v;
    logic [RobIdxWDefault-1:0] idx;
  } lsq_slot_t;

  // Width needed to hold a count in the range 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lsq_slot_compact.sv
// Combinational prefix-sum compactor: packs the ROB indices of the set mask bits into
// dense, lowest-slot-first {valid, idx} slots and reports how many slots are used.
module lsq_slot_compact
  import lsq_pkg::*;
#(
  parameter int unsigned DISP_W    = DispWDefault,
  parameter int unsigned ROB_IDX_W = RobIdxWDefault,
  parameter int unsigned ROB_DEPTH = 128,
  localparam int unsigned SlotW    = ROB_IDX_W + 1,
  localparam int unsigned CntW     = cnt_width(DISP_W)
) (
  input  logic [DISP_W-1:0]       mask_i,
  input  logic [ROB_IDX_W-1:0]    base_i,
  output logic [DISP_W*SlotW-1:0] slots_o,
  output logic [CntW-1:0]         cnt_o
);

  localparam logic [ROB_IDX_W:0] DepthW = SlotW'(ROB_DEPTH);

  logic [ROB_IDX_W:0]   sum [DISP_W];
  logic [ROB_IDX_W-1:0] idx [DISP_W];
  logic [CntW-1:0]      pos;

  // Base is always below ROB_DEPTH, so one conditional subtract wraps any offset < DISP_W.
  always_comb begin
    for (int unsigned i = 0; i < DISP_W; i++) begin
      sum[i] = {1'b0, base_i} + SlotW'(i);
      if (sum[i] >= DepthW) begin
        idx[i] = ROB_IDX_W'(sum[i] - DepthW);
      end else begin
        idx[i] = sum[i][ROB_IDX_W-1:0];
      end
    end
  end

  always_comb begin
    slots_o = '0;
    pos     = '0;
    for (int unsigned i = 0; i < DISP_W; i++) begin
      if (mask_i[i]) begin
        slots_o[pos*SlotW +: SlotW] = {1'b1, idx[i]};
        pos = pos + 1'b1;
      end
    end
    cnt_o = pos;
  end

endmodule

// File: rtl/lsq_dispatch_packer.sv
// Registered, credit-checked packer of load/store ROB indices from dispatch toward the LSQ,
// with valid/ready output handshake, load/store queue credit tracking and flush handling.
module lsq_dispatch_packer
  import lsq_pkg::*;
#(
  parameter int unsigned DISP_W    = DispWDefault,
  parameter int unsigned ROB_IDX_W = RobIdxWDefault,
  parameter int unsigned ROB_DEPTH = 128,
  parameter int unsigned LQ_DEPTH  = 16,
  parameter int unsigned SQ_DEPTH  = 16,
  localparam int unsigned SlotW    = ROB_IDX_W + 1,
  localparam int unsigned CntW     = cnt_width(DISP_W),
  localparam int unsigned LqW      = cnt_width(LQ_DEPTH),
  localparam int unsigned SqW      = cnt_width(SQ_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    disp_valid_i,
  output logic                    disp_ready_o,
  input  logic [DISP_W-1:0]       disp_is_ld_i,
  input  logic [DISP_W-1:0]       disp_is_st_i,
  input  logic [ROB_IDX_W-1:0]    rob_base_idx_i,
  output logic                    lsq_valid_o,
  input  logic                    lsq_ready_i,
  output logic [DISP_W*SlotW-1:0] ld_indx_to_lsq_o,
  output logic [DISP_W*SlotW-1:0] st_indx_to_lsq_o,
  output logic [CntW-1:0]         ld_cnt_o,
  output logic [CntW-1:0]         st_cnt_o,
  input  logic [LqW-1:0]          ld_free_cnt_i,
  input  logic [SqW-1:0]          st_free_cnt_i,
  output logic                    credit_err_o
);

  logic [DISP_W*SlotW-1:0] ld_slots, st_slots;
  logic [CntW-1:0]         nld, nst;

  lsq_slot_compact #(
    .DISP_W    (DISP_W),
    .ROB_IDX_W (ROB_IDX_W),
    .ROB_DEPTH (ROB_DEPTH)
  ) u_ld_compact (
    .mask_i  (disp_is_ld_i),
    .base_i  (rob_base_idx_i),
    .slots_o (ld_slots),
    .cnt_o   (nld)
  );

  lsq_slot_compact #(
    .DISP_W    (DISP_W),
    .ROB_IDX_W (ROB_IDX_W),
    .ROB_DEPTH (ROB_DEPTH)
  ) u_st_compact (
    .mask_i  (disp_is_st_i),
    .base_i  (rob_base_idx_i),
    .slots_o (st_slots),
    .cnt_o   (nst)
  );

  logic                    valid_q, valid_d;
  logic [DISP_W*SlotW-1:0] ld_slots_q, ld_slots_d;
  logic [DISP_W*SlotW-1:0] st_slots_q, st_slots_d;
  logic [CntW-1:0]         ld_cnt_q, ld_cnt_d;
  logic [CntW-1:0]         st_cnt_q, st_cnt_d;
  logic [LqW-1:0]          lq_cred_q, lq_cred_d;
  logic [SqW-1:0]          sq_cred_q, sq_cred_d;
  logic                    credit_err_q, credit_err_d;

  logic        accept;
  logic        flush_ret;
  logic [31:0] lq_sum, sq_sum;

  assign disp_ready_o = !flush_i && (!valid_q || lsq_ready_i) &&
                        (32'(nld) <= 32'(lq_cred_q)) && (32'(nst) <= 32'(sq_cred_q));
  assign accept       = disp_valid_i && disp_ready_o;

  // A held bundle the LSQ never took is dropped on flush, so its credits come back.
  assign flush_ret = flush_i && valid_q && !lsq_ready_i;

  always_comb begin
    valid_d    = valid_q;
    ld_slots_d = ld_slots_q;
    st_slots_d = st_slots_q;
    ld_cnt_d   = ld_cnt_q;
    st_cnt_d   = st_cnt_q;
    if (flush_i) begin
      valid_d    = 1'b0;
      ld_slots_d = '0;
      st_slots_d = '0;
      ld_cnt_d   = '0;
      st_cnt_d   = '0;
    end else if (accept) begin
      valid_d    = 1'b1;
      ld_slots_d = ld_slots;
      st_slots_d = st_slots;
      ld_cnt_d   = nld;
      st_cnt_d   = nst;
    end else if (valid_q && lsq_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    lq_sum = 32'(lq_cred_q) + 32'(ld_free_cnt_i);
    sq_sum = 32'(sq_cred_q) + 32'(st_free_cnt_i);
    if (accept) begin
      lq_sum = lq_sum - 32'(nld);
      sq_sum = sq_sum - 32'(nst);
    end
    if (flush_ret) begin
      lq_sum = lq_sum + 32'(ld_cnt_q);
      sq_sum = sq_sum + 32'(st_cnt_q);
    end
    credit_err_d = credit_err_q;
    if (lq_sum > 32'(LQ_DEPTH)) begin
      lq_cred_d    = LqW'(LQ_DEPTH);
      credit_err_d = 1'b1;
    end else begin
      lq_cred_d = LqW'(lq_sum);
    end
    if (sq_sum > 32'(SQ_DEPTH)) begin
      sq_cred_d    = SqW'(SQ_DEPTH);
      credit_err_d = 1'b1;
    end else begin
      sq_cred_d = SqW'(sq_sum);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      ld_slots_q   <= '0;
      st_slots_q   <= '0;
      ld_cnt_q     <= '0;
      st_cnt_q     <= '0;
      lq_cred_q    <= LqW'(LQ_DEPTH);
      sq_cred_q    <= SqW'(SQ_DEPTH);
      credit_err_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      ld_slots_q   <= ld_slots_d;
      st_slots_q   <= st_slots_d;
      ld_cnt_q     <= ld_cnt_d;
      st_cnt_q     <= st_cnt_d;
      lq_cred_q    <= lq_cred_d;
      sq_cred_q    <= sq_cred_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign lsq_valid_o      = valid_q;
  assign ld_indx_to_lsq_o = ld_slots_q;
  assign st_indx_to_lsq_o = st_slots_q;
  assign ld_cnt_o         = ld_cnt_q;
  assign st_cnt_o         = st_cnt_q;
  assign credit_err_o     = credit_err_q;

endmodule

// File: tb/tb_lsq_dispatch_packer.sv
// Bench for lsq_dispatch_packer: directed and random steps checked against a queue-based model.
module tb_lsq_dispatch_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, disp_valid, disp_ready, lsq_valid, lsq_ready, credit_err;
  logic [3:0]  disp_is_ld, disp_is_st;
  logic [6:0]  rob_base_idx;
  logic [31:0] ld_flat, st_flat;
  logic [2:0]  ld_cnt, st_cnt;
  logic [4:0]  ld_free_cnt, st_free_cnt;

  // Second instance with a non-power-of-2 ROB.
  logic        b_flush, b_dv, b_drdy, b_lvalid, b_lrdy, b_err;
  logic [3:0]  b_ld, b_st;
  logic [6:0]  b_base;
  logic [31:0] b_ldf, b_stf;
  logic [2:0]  b_ldc, b_stc;
  logic [4:0]  b_lfree, b_sfree;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_valid, m_err, m_known;
  logic [31:0] m_ldf, m_stf;
  int          m_ldc, m_stc, m_lq, m_sq;

  always #5 clk = ~clk;

  lsq_dispatch_packer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_i          (flush),
    .disp_valid_i     (disp_valid),
    .disp_ready_o     (disp_ready),
    .disp_is_ld_i     (disp_is_ld),
    .disp_is_st_i     (disp_is_st),
    .rob_base_idx_i   (rob_base_idx),
    .lsq_valid_o      (lsq_valid),
    .lsq_ready_i      (lsq_ready),
    .ld_indx_to_lsq_o (ld_flat),
    .st_indx_to_lsq_o (st_flat),
    .ld_cnt_o         (ld_cnt),
    .st_cnt_o         (st_cnt),
    .ld_free_cnt_i    (ld_free_cnt),
    .st_free_cnt_i    (st_free_cnt),
    .credit_err_o     (credit_err)
  );

  lsq_dispatch_packer #(.ROB_DEPTH(100)) dut100 (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_i          (b_flush),
    .disp_valid_i     (b_dv),
    .disp_ready_o     (b_drdy),
    .disp_is_ld_i     (b_ld),
    .disp_is_st_i     (b_st),
    .rob_base_idx_i   (b_base),
    .lsq_valid_o      (b_lvalid),
    .lsq_ready_i      (b_lrdy),
    .ld_indx_to_lsq_o (b_ldf),
    .st_indx_to_lsq_o (b_stf),
    .ld_cnt_o         (b_ldc),
    .st_cnt_o         (b_stc),
    .ld_free_cnt_i    (b_lfree),
    .st_free_cnt_i    (b_sfree),
    .credit_err_o     (b_err)
  );

  function automatic logic [31:0] pack(input logic [3:0] m, input int base, input int depth);
    int          q[$];
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (m[i]) q.push_back((base + i) % depth);
    foreach (q[k]) r[k*8 +: 8] = {1'b1, 7'(q[k])};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_valid = 0; m_err = 0; m_known = 1;
    m_ldf = '0; m_stf = '0; m_ldc = 0; m_stc = 0;
    m_lq = 16; m_sq = 16;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".lsq_valid"}, 32'(lsq_valid), 32'(m_valid));
    chk({tag, ".credit_err"}, 32'(credit_err), 32'(m_err));
    chk({tag, ".lq_cred"}, 32'(dut.lq_cred_q), 32'(m_lq));
    chk({tag, ".sq_cred"}, 32'(dut.sq_cred_q), 32'(m_sq));
    if (m_known) begin
      chk({tag, ".ld_slots"}, ld_flat, m_ldf);
      chk({tag, ".st_slots"}, st_flat, m_stf);
      chk({tag, ".ld_cnt"}, 32'(ld_cnt), 32'(m_ldc));
      chk({tag, ".st_cnt"}, 32'(st_cnt), 32'(m_stc));
    end
  endtask

  // Entered and left at posedge+1: drive, check disp_ready, clock, check registered state.
  task automatic step(input string tag, input bit fl, input bit dv, input logic [3:0] ld,
                      input logic [3:0] st, input int base, input bit rdy,
                      input int lfree, input int sfree);
    bit ready_e, acc;
    int nld, nst, lq_n, sq_n;
    flush = fl; disp_valid = dv; disp_is_ld = ld; disp_is_st = st;
    rob_base_idx = 7'(base); lsq_ready = rdy;
    ld_free_cnt = 5'(lfree); st_free_cnt = 5'(sfree);
    #1;
    nld = $countones(ld);
    nst = $countones(st);
    ready_e = !fl && (!m_valid || rdy) && nld <= m_lq && nst <= m_sq;
    chk({tag, ".disp_ready"}, 32'(disp_ready), 32'(ready_e));
    acc  = dv && ready_e;
    lq_n = m_lq + lfree - (acc ? nld : 0) + ((fl && m_valid && !rdy) ? m_ldc : 0);
    sq_n = m_sq + sfree - (acc ? nst : 0) + ((fl && m_valid && !rdy) ? m_stc : 0);
    if (lq_n > 16) begin lq_n = 16; m_err = 1; end
    if (sq_n > 16) begin sq_n = 16; m_err = 1; end
    if (fl) begin
      m_valid = 0; m_known = 1; m_ldf = '0; m_stf = '0; m_ldc = 0; m_stc = 0;
    end else if (acc) begin
      m_valid = 1; m_known = 1;
      m_ldf = pack(ld, base, 128); m_stf = pack(st, base, 128);
      m_ldc = nld; m_stc = nst;
    end else if (m_valid && rdy) begin
      m_valid = 0; m_known = 0;
    end
    m_lq = lq_n; m_sq = sq_n;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 0; disp_valid = 0; disp_is_ld = '0; disp_is_st = '0; rob_base_idx = '0;
    lsq_ready = 0; ld_free_cnt = '0; st_free_cnt = '0;
    b_flush = 0; b_dv = 0; b_ld = '0; b_st = '0; b_base = '0; b_lrdy = 0;
    b_lfree = '0; b_sfree = '0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    reset_model();
    check_outputs("reset");

    step("pack_b5", 0, 1, 4'b1010, 4'b0101, 5, 1, 0, 0);
    step("wrap_b126", 0, 1, 4'b1111, 4'b0000, 126, 1, 0, 0);
    step("burn1", 0, 1, 4'b1111, 4'b0000, 10, 1, 0, 0);
    step("burn2", 0, 1, 4'b1111, 4'b0000, 20, 1, 0, 0);
    step("burn3", 0, 1, 4'b0001, 4'b0000, 30, 1, 0, 0);
    step("cred_short", 0, 1, 4'b0011, 4'b0000, 40, 1, 1, 0);
    step("cred_ok", 0, 1, 4'b0011, 4'b0000, 40, 1, 0, 0);
    step("hold1", 0, 1, 4'b0001, 4'b0010, 50, 0, 10, 0);
    step("hold2", 0, 1, 4'b0001, 4'b0010, 50, 0, 0, 0);
    step("hold3", 0, 1, 4'b0001, 4'b0010, 50, 0, 0, 0);
    step("release", 0, 1, 4'b0001, 4'b0010, 50, 1, 0, 0);
    step("ld2", 0, 1, 4'b0011, 4'b0000, 60, 1, 3, 0);
    step("flush_held", 1, 1, 4'b1111, 4'b0000, 70, 0, 0, 0);
    step("refill", 0, 0, 4'b0000, 4'b0000, 0, 1, 4, 0);
    step("overflow", 0, 0, 4'b0000, 4'b0000, 0, 1, 1, 0);
    step("err_sticky", 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0);
    step("empty_bundle", 0, 1, 4'b0000, 4'b0000, 9, 1, 0, 0);
    step("both_bits", 0, 1, 4'b0110, 4'b0111, 127, 1, 0, 0);

    for (int n = 0; n < 300; n++) begin
      step("rand", ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom), $urandom_range(0, 127), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Asynchronous reset between edges with a bundle in flight.
    step("pre_rst", 0, 1, 4'b1001, 4'b0100, 33, 0, 0, 0);
    flush = 0; disp_valid = 0; disp_is_ld = '0; disp_is_st = '0; lsq_ready = 0;
    ld_free_cnt = '0; st_free_cnt = '0;
    #3;
    rst_n = 1'b0;
    #1;
    reset_model();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("post_rst");
    step("after_rst", 0, 1, 4'b1010, 4'b0101, 5, 1, 0, 0);

    b_base = 7'd98; b_ld = 4'b1111; b_dv = 1; b_lrdy = 1;
    @(posedge clk);
    #1;
    chk("depth100.valid", 32'(b_lvalid), 32'd1);
    chk("depth100.ld_slots", b_ldf, pack(4'b1111, 98, 100));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
